// File: rtl/conv_window_gen.sv
`default_nettype none
// ============================================================================
// conv_window_gen : streaming 3x3 sliding-window generator feeding the conv ALU.
// Define CONV_WIN_STRIDE2_EN to emit only even-aligned windows (stride 2).
// Revision: 1.0
// ============================================================================
module conv_window_gen #(
  parameter  int N    = 8,
  parameter  int IMG  = 28,
  localparam int FOUT = 9 * N,
  localparam int CW   = $clog2(IMG)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N-1:0]    in_pixel,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [FOUT-1:0] win_out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CW-1:0]   out_row,
  output logic [CW-1:0]   out_col,
  output logic            frame_done
);

  localparam logic [CW-1:0] C_LAST = CW'(IMG - 1);
  localparam logic [CW-1:0] C_TWO  = CW'(2);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  logic [CW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic            frame_done_q, frame_done_d;
  logic            out_valid_q, out_valid_d;
  logic [FOUT-1:0] win_out_q, win_out_d;
  logic [CW-1:0]   out_row_q, out_row_d;
  logic [CW-1:0]   out_col_q, out_col_d;

  logic [N-1:0]    lb0_q [IMG];
  logic [N-1:0]    lb0_d [IMG];
  logic [N-1:0]    lb1_q [IMG];
  logic [N-1:0]    lb1_d [IMG];
  logic [N-1:0]    win_q [9];
  logic [N-1:0]    win_d [9];

  logic            accept;
  logic            emit;

  assign in_ready   = !reset && (!out_valid_q || out_ready);
  assign accept     = in_valid && in_ready;
  assign win_out    = win_out_q;
  assign out_valid  = out_valid_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign frame_done = frame_done_q;

  always_comb begin
    row_d        = row_q;
    col_d        = col_q;
    frame_done_d = 1'b0;
    if (accept) begin
      if (col_q == C_LAST) begin
        col_d = '0;
        if (row_q == C_LAST) begin
          row_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          row_d = row_q + C_ONE;
        end
      end else begin
        col_d = col_q + C_ONE;
      end
    end
  end

  // Row 0 of the window comes from the older line buffer, row 2 is the live pixel.
  always_comb begin
    lb0_d = lb0_q;
    lb1_d = lb1_q;
    win_d = win_q;
    if (accept) begin
      lb0_d[col_q] = in_pixel;
      lb1_d[col_q] = lb0_q[col_q];
      for (int r = 0; r < 3; r++) begin
        win_d[r*3]     = win_q[r*3 + 1];
        win_d[r*3 + 1] = win_q[r*3 + 2];
      end
      win_d[2] = lb1_q[col_q];
      win_d[5] = lb0_q[col_q];
      win_d[8] = in_pixel;
    end
  end

  always_comb begin
    emit = accept && (row_q >= C_TWO) && (col_q >= C_TWO);
`ifdef CONV_WIN_STRIDE2_EN
    // (row-2) and (col-2) are even exactly when row and col are even.
    emit = emit && !row_q[0] && !col_q[0];
`endif
  end

  always_comb begin
    out_valid_d = out_valid_q;
    win_out_d   = win_out_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    if (emit) begin
      out_valid_d = 1'b1;
      for (int k = 0; k < 9; k++) begin
        win_out_d[k*N +: N] = win_d[k];
      end
      out_row_d = row_q - C_TWO;
      out_col_d = col_q - C_TWO;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      row_q        <= '0;
      col_q        <= '0;
      frame_done_q <= 1'b0;
      out_valid_q  <= 1'b0;
      win_out_q    <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
    end else begin
      row_q        <= row_d;
      col_q        <= col_d;
      frame_done_q <= frame_done_d;
      out_valid_q  <= out_valid_d;
      win_out_q    <= win_out_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
    end
  end

  // Storage is always overwritten within a frame before it reaches an output.
  always_ff @(posedge clock) begin
    lb0_q <= lb0_d;
    lb1_q <= lb1_d;
    win_q <= win_d;
  end

endmodule
`default_nettype wire
